// File: rtl/dmem_access_pkg.sv
// dmem_access_pkg: shared types, segment default and access legality check for the data memory unit
package dmem_access_pkg;
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;
  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    LD_DATA,
    ST_WR,
    RMW_RD,
    RMW_DATA,
    RMW_WR,
    RESP
  } state_e;
  localparam logic [31:0] DEFAULT_SEG_START = 32'h10010000;
  function automatic logic access_error(input logic [31:0] addr, input logic [1:0] size,
                                        input logic [31:0] start, input logic [31:0] bytes);
    logic [31:0] off;
    off = addr - start;
    return (size == 2'b11) || (size == SIZE_HALF && addr[0]) ||
           (size == SIZE_WORD && addr[1:0] != 2'b00) || (off >= bytes);
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian load extract/extend and sub-word store merge
module dmem_lane_align
  import dmem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  size_e       size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);
  logic [4:0]  sh;
  logic [15:0] part;
  logic [31:0] mask;
  assign sh      = size_i == SIZE_HALF ? {lane_i[1], 4'b0000} : {lane_i, 3'b000};
  assign part    = 16'(rdata_i >> sh);
  assign mask    = (size_i == SIZE_BYTE ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
  assign load_o  = size_i == SIZE_BYTE ? {{24{~unsigned_i & part[7]}}, part[7:0]} :
                   size_i == SIZE_HALF ? {{16{~unsigned_i & part[15]}}, part} : rdata_i;
  assign merge_o = size_i == SIZE_WORD ? wdata_i : (rdata_i & ~mask) | ((wdata_i << sh) & mask);
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store initiator for a word-wide synchronous data memory
module dmem_access_unit
  import dmem_access_pkg::*;
#(
  parameter logic [31:0] DATA_SEGMENT_START_ADDRESS = DEFAULT_SEG_START,
  parameter int unsigned DATA_MEMORY_WORDS          = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_write_data,
  input  logic [31:0] dmem_read_data
);
  localparam logic [31:0] SEG_BYTES = 32'(DATA_MEMORY_WORDS * 4);
  state_e      state_q, state_d;
  size_e       size_q;
  logic        uns_q, err_q, rd_q, wr_q, valid_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q, rdata_q, addr_q, wbuf_q;
  logic        accept, req_err;
  logic [31:0] load_data, merged;
  assign req_ready       = state_q == IDLE;
  assign accept          = req_valid && req_ready;
  assign req_err         = access_error(req_address, req_size, DATA_SEGMENT_START_ADDRESS, SEG_BYTES);
  assign resp_valid      = valid_q;
  assign resp_error      = valid_q & err_q;
  assign resp_rdata      = rdata_q;
  assign dmem_read       = rd_q;
  assign dmem_write      = wr_q;
  assign dmem_address    = addr_q;
  assign dmem_write_data = wbuf_q;
  dmem_lane_align u_align (
    .rdata_i   (dmem_read_data),
    .wdata_i   (wdata_q),
    .size_i    (size_q),
    .lane_i    (lane_q),
    .unsigned_i(uns_q),
    .load_o    (load_data),
    .merge_o   (merged)
  );
  // next state: errors skip straight to the response, sub-word stores take the read-modify-write path
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = req_err ? RESP : !req_write ? LD_RD :
                                      req_size == SIZE_WORD ? ST_WR : RMW_RD;
      LD_RD:    state_d = LD_DATA;
      LD_DATA:  state_d = RESP;
      ST_WR:    state_d = RESP;
      RMW_RD:   state_d = RMW_DATA;
      RMW_DATA: state_d = RMW_WR;
      RMW_WR:   state_d = RESP;
      default:  state_d = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end
  // registered strobes and response follow the state being entered; request fields latch on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      size_q  <= SIZE_BYTE;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      lane_q  <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rd_q    <= state_d == LD_RD || state_d == RMW_RD;
      wr_q    <= state_d == ST_WR || state_d == RMW_WR;
      valid_q <= state_d == RESP;
      if (accept) begin
        size_q  <= size_e'(req_size);
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        lane_q  <= req_address[1:0];
        wdata_q <= req_wdata;
        rdata_q <= '0;
        if (!req_err) addr_q <= {req_address[31:2], 2'b00};
        if (!req_err && req_write && req_size == SIZE_WORD) wbuf_q <= req_wdata;
      end
      if (state_q == LD_DATA) rdata_q <= load_data;
      if (state_q == RMW_DATA) wbuf_q <= merged;
    end
  end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed table-driven bench with a word memory model and strobe monitor
module tb_dmem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_address, req_wdata;
  logic        resp_valid, resp_error, dmem_read, dmem_write;
  logic [31:0] resp_rdata, dmem_address, dmem_write_data, dmem_read_data;
  logic [31:0] mem [256] = '{default: '0};
  logic [31:0] exp_addr;
  int n_rd = 0, n_wr = 0, n_both = 0, n_bad = 0, n_resp = 0;
  int total = 0, passed = 0;
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } vec_t;
  vec_t vecs[22];

  dmem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_write_data(dmem_write_data),
    .dmem_read_data(dmem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmem_write) mem[dmem_address[9:2]] <= dmem_write_data;
    if (dmem_read) dmem_read_data <= mem[dmem_address[9:2]];
  end

  always @(negedge clk) begin
    if (dmem_read) n_rd++;
    if (dmem_write) n_wr++;
    if (dmem_read && dmem_write) n_both++;
    if ((dmem_read || dmem_write) && dmem_address != exp_addr) n_bad++;
    if (resp_valid) n_resp++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input int lat,
                              input int nrd, input int nwr);
    vec_t v;
    v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.lat = lat; v.nrd = nrd; v.nwr = nwr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int lat, rd0, wr0, both0, bad0, resp0;
    logic [31:0] got_rdata;
    logic got_err;
    @(negedge clk); #1;
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    rd0 = n_rd; wr0 = n_wr; both0 = n_both; bad0 = n_bad; resp0 = n_resp;
    exp_addr = {v.addr[31:2], 2'b00};
    req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
    req_address = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 10);
    got_rdata = resp_rdata;
    got_err = resp_error;
    @(negedge clk); #1;
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " rdata"}, got_rdata, v.rdata);
    chk({tag, " error"}, 32'(got_err), 32'(v.err));
    chk({tag, " pulse_end"}, 32'(resp_valid), 32'd0);
    chk({tag, " resp_count"}, 32'(n_resp - resp0), 32'd1);
    chk({tag, " reads"}, 32'(n_rd - rd0), 32'(v.nrd));
    chk({tag, " writes"}, 32'(n_wr - wr0), 32'(v.nwr));
    chk({tag, " strobe_overlap"}, 32'(n_both - both0), 32'd0);
    chk({tag, " strobe_addr"}, 32'(n_bad - bad0), 32'd0);
  endtask

  initial begin
    int rd0, wr0, resp0;
    vecs[0]  = mk(1, 2'b10, 0, 32'h10010004, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1);
    vecs[1]  = mk(0, 2'b10, 0, 32'h10010004, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0);
    vecs[2]  = mk(1, 2'b00, 0, 32'h10010005, 32'h00000080, 32'h0, 0, 4, 1, 1);
    vecs[3]  = mk(0, 2'b10, 0, 32'h10010004, 32'h0, 32'hDEAD80EF, 0, 3, 1, 0);
    vecs[4]  = mk(0, 2'b00, 0, 32'h10010005, 32'h0, 32'hFFFFFF80, 0, 3, 1, 0);
    vecs[5]  = mk(0, 2'b00, 1, 32'h10010005, 32'h0, 32'h00000080, 0, 3, 1, 0);
    vecs[6]  = mk(1, 2'b01, 0, 32'h10010006, 32'h00001234, 32'h0, 0, 4, 1, 1);
    vecs[7]  = mk(0, 2'b10, 0, 32'h10010004, 32'h0, 32'h123480EF, 0, 3, 1, 0);
    vecs[8]  = mk(0, 2'b01, 0, 32'h10010006, 32'h0, 32'h00001234, 0, 3, 1, 0);
    vecs[9]  = mk(0, 2'b01, 0, 32'h10010004, 32'h0, 32'hFFFF80EF, 0, 3, 1, 0);
    vecs[10] = mk(0, 2'b01, 1, 32'h10010004, 32'h0, 32'h000080EF, 0, 3, 1, 0);
    vecs[11] = mk(0, 2'b00, 0, 32'h10010007, 32'h0, 32'h00000012, 0, 3, 1, 0);
    vecs[12] = mk(0, 2'b10, 0, 32'h10010002, 32'h0, 32'h0, 1, 1, 0, 0);
    vecs[13] = mk(0, 2'b01, 0, 32'h10010001, 32'h0, 32'h0, 1, 1, 0, 0);
    vecs[14] = mk(0, 2'b10, 0, 32'h1000FFFC, 32'h0, 32'h0, 1, 1, 0, 0);
    vecs[15] = mk(0, 2'b10, 0, 32'h10010400, 32'h0, 32'h0, 1, 1, 0, 0);
    vecs[16] = mk(0, 2'b11, 0, 32'h10010004, 32'h0, 32'h0, 1, 1, 0, 0);
    vecs[17] = mk(0, 2'b10, 0, 32'h100103FC, 32'h0, 32'h0, 0, 3, 1, 0);
    vecs[18] = mk(1, 2'b00, 0, 32'h100103FF, 32'h123456AB, 32'h0, 0, 4, 1, 1);
    vecs[19] = mk(0, 2'b10, 0, 32'h100103FC, 32'h0, 32'hAB000000, 0, 3, 1, 0);
    vecs[20] = mk(1, 2'b00, 0, 32'h10010400, 32'h000000FF, 32'h0, 1, 1, 0, 0);
    vecs[21] = mk(1, 2'b01, 0, 32'h10010005, 32'h0000FFFF, 32'h0, 1, 1, 0, 0);
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_address = '0; req_wdata = '0; exp_addr = '0;
    repeat (2) @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("reset resp", {30'd0, resp_valid, resp_error}, 32'd0);
    chk("reset address", dmem_address, 32'd0);
    chk("reset wdata", dmem_write_data, 32'd0);
    chk("reset rdata", resp_rdata, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 22; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    // reset while the read-modify-write is merging
    @(negedge clk); #1;
    wr0 = n_wr; resp0 = n_resp;
    exp_addr = 32'h10010004;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_address = 32'h10010004; req_wdata = 32'h00000055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstmid address", dmem_address, 32'd0);
    chk("rstmid wdata", dmem_write_data, 32'd0);
    chk("rstmid strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("rstmid ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("rstmid no_write", 32'(n_wr - wr0), 32'd0);
    chk("rstmid no_resp", 32'(n_resp - resp0), 32'd0);
    run_vec(mk(0, 2'b10, 0, 32'h10010004, 32'h0, 32'h123480EF, 0, 3, 1, 0), "after_rst");
    // request held valid: only accepted when the unit is back in IDLE
    @(negedge clk); #1;
    rd0 = n_rd; resp0 = n_resp;
    exp_addr = 32'h10010004;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_address = 32'h10010004;
    @(negedge clk);
    chk("held ready_busy", 32'(req_ready), 32'd0);
    repeat (7) @(negedge clk);
    #1;
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("held reads", 32'(n_rd - rd0), 32'd2);
    chk("held resps", 32'(n_resp - resp0), 32'd2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
